main_memory: RTL and testbench
==============================

MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10, word address width, laid out as {tag[2:0], index[4:0], offset[1:0]}.
REQ-003 Parameter Block_Size_Byte, default 16, refill block size; words per block = Block_Size_Byte*8/WIDTH = 4.
REQ-004 Parameter LATENCY, default 4, access latency in clk cycles; legal range 1..15.
REQ-005 Port clk  input  1  single clock; all state changes on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset.
REQ-007 Port mem_read  input  1  block-read request, refill path for a cache read miss.
REQ-008 Port mem_write  input  1  word-write request, write-through path.
REQ-009 Port address  input  ADDR_WIDTH  word address of the request.
REQ-010 Port write_data  input  WIDTH  word to store on a write request.
REQ-011 Port read_ablock  output  Block_Size_Byte*8  block returned by a read.
REQ-012 Port ready  output  1  one-cycle completion pulse for the accepted request.
REQ-013 Port busy  output  1  high while a request is outstanding.

Function
REQ-014 Storage SHALL be 2**ADDR_WIDTH words of WIDTH bits.
REQ-015 The FSM SHALL have three states: IDLE, READ_WAIT and WRITE_WAIT. busy SHALL be 1 in either WAIT state.
REQ-016 In IDLE, a rising edge with mem_write=1 SHALL accept a write. address and write_data SHALL be latched, the latency counter loaded, and the FSM SHALL move to WRITE_WAIT.
REQ-017 In IDLE, a rising edge with mem_read=1 and mem_write=0 SHALL accept a read. address SHALL be latched, the counter loaded, and the FSM SHALL move to READ_WAIT.
REQ-018 If mem_read and mem_write are both 1 in IDLE, the write SHALL win and the read SHALL be dropped; the requester must re-issue the read.
REQ-019 Requests presented while busy=1 SHALL be ignored, with no queuing and no effect on the latched address or data.
REQ-020 Completion: if a request is accepted at edge T, the completion edge SHALL be T+LATENCY. ready SHALL be 1 for exactly the cycle following the completion edge, and busy SHALL be 0 in that cycle.
REQ-021 At completion, the FSM SHALL return to IDLE, and a new request MAY be accepted on the edge that ends the ready cycle.
REQ-022 Write completion SHALL store latched write_data at the latched address on the completion edge. Before that edge, memory SHALL be unchanged.
REQ-023 Read completion SHALL load read_ablock with {mem[A|3], mem[A|2], mem[A|1], mem[A|0]}, where A = {latched address[ADDR_WIDTH-1:2], 2'b00}. Word offset 0 SHALL occupy bits [WIDTH-1:0]; address[1:0] SHALL be ignored.
REQ-024 read_ablock SHALL hold its value until the next read completion. Write requests SHALL NOT alter read_ablock.
REQ-025 The read path SHALL see all prior completed writes; a write completing 1 cycle before a read is accepted SHALL be visible in that read's block.
REQ-026 ready SHALL never be 1 in two consecutive cycles.

Reset
REQ-027 reset=0 SHALL immediately, without waiting for a clock edge, force IDLE, busy=0, ready=0, read_ablock=0 and counter=0.
REQ-028 Reset SHALL initialise memory word k to value k, zero-extended to WIDTH.
REQ-029 Reset asserted mid-operation SHALL abort the request: no write is committed, no ready pulse is issued, and memory is re-initialised.
REQ-030 After reset deasserts, the first rising edge SHALL accept a pending request.

Verification
REQ-031 Read after reset: mem_read=1, address=0x02D at edge T -> ready=1 in the cycle after T+4; read_ablock=0x0000002F_0000002E_0000002D_0000002C; busy=1 for 4 cycles.
REQ-032 Write then read: write 0xDEADBEEF to 0x105, then read 0x104 -> read_ablock[63:32]=0xDEADBEEF and the other words are 0x104, 0x106, 0x107.
REQ-033 Simultaneous requests: mem_read=mem_write=1 with address 0x010 and data 0x12345678 -> only the write completes, read_ablock is unchanged, and exactly one ready pulse occurs.
REQ-034 Request while busy: a second mem_read to 0x3FC is issued 2 cycles after the first read is accepted -> it is ignored, with exactly one ready pulse carrying the first address's block.
REQ-035 Reset mid-write: a write of 0xFFFFFFFF to 0x020 is accepted and reset is pulsed 2 cycles later -> no ready pulse, and a following read of 0x020 returns word 0x00000020 in bits [31:0].
REQ-036 LATENCY=1 back-to-back: alternating reads and writes held continuously -> one ready pulse every 2 cycles, each with the correct data.

Source files
------------

// File: rtl/main_memory.sv
// -----------------------------------------------------------------------------
// main_memory
//
// Backing store for a direct-mapped cache. It returns whole blocks on the read
// (miss refill) path and accepts single words on the write-through path. Every
// access takes a fixed LATENCY cycles. Only one request is outstanding at a
// time. Requests that arrive while busy are dropped, not queued.
//
// Parameters
//   WIDTH           data word width in bits
//   ADDR_WIDTH      word address width, {tag, index, offset}
//   Block_Size_Byte refill block size in bytes
//   LATENCY         cycles from accept edge to completion edge (1..15)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset; also re-initialises storage
//   mem_read     block-read request (ignored when mem_write is also high)
//   mem_write    word-write request
//   address      word address of the request
//   write_data   word stored by a write request
//   read_ablock  last block returned by a read; offset 0 is in the low bits
//   ready        one-cycle completion pulse
//   busy         high while a request is outstanding
// -----------------------------------------------------------------------------
module main_memory #(
  parameter int WIDTH           = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int Block_Size_Byte = 16,
  parameter int LATENCY         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic [WIDTH-1:0]             write_data,
  output logic [Block_Size_Byte*8-1:0] read_ablock,
  output logic                         ready,
  output logic                         busy
);

  localparam int BLOCK_BITS = Block_Size_Byte * 8;
  localparam int WORDS      = BLOCK_BITS / WIDTH;
  localparam int OFF_W      = $clog2(WORDS);
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  // The counter is loaded with LATENCY-1 so that it reaches zero on the
  // completion edge, which is LATENCY edges after the accept edge.
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [3:0]              count_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [WIDTH-1:0]        data_reg;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [BLOCK_BITS-1:0]   block_next;
  logic                    wr_commit;

  assign busy      = (state_reg != IDLE);
  assign wr_commit = (state_reg == WRITE_WAIT) && (count_reg == 4'd0);

  // Gather the aligned block around the latched address. The low offset bits
  // of the request are replaced by each word's position in the block.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_block
      assign block_next[gi*WIDTH +: WIDTH] =
        mem[{addr_reg[ADDR_WIDTH-1:OFF_W], OFF_W'(gi)}];
    end
  endgenerate

  // Storage. Reset loads word k with k so that refills are recognisable. A
  // write lands only on its completion edge. A read that completes later
  // therefore sees it through block_next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= WIDTH'(k);
      end
    end else if (wr_commit) begin
      mem[addr_reg] <= data_reg;
    end
  end

  // Request FSM. ready is registered on the completion edge. This makes the
  // pulse occupy the first IDLE cycle, so it can never repeat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      count_reg   <= 4'd0;
      addr_reg    <= '0;
      data_reg    <= '0;
      ready       <= 1'b0;
      read_ablock <= '0;
    end else begin
      ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A write takes priority. A read that coincides with it is dropped.
          if (mem_write) begin
            addr_reg  <= address;
            data_reg  <= write_data;
            count_reg <= LAT_M1;
            state_reg <= WRITE_WAIT;
          end else if (mem_read) begin
            addr_reg  <= address;
            count_reg <= LAT_M1;
            state_reg <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (count_reg == 4'd0) begin
            read_ablock <= block_next;
            ready       <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            count_reg <= count_reg - 4'd1;
          end
        end
        WRITE_WAIT: begin
          if (count_reg == 4'd0) begin
            ready     <= 1'b1;
            state_reg <= IDLE;
          end else begin
            count_reg <= count_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// -----------------------------------------------------------------------------
// tb_main_memory
//
// Directed bench for main_memory. dut0 uses the default latency of 4 and dut1
// uses latency 1. Both instances share the clock and the reset. A table of
// requests with hand-computed blocks drives dut0. Short hand-written sequences
// cover the corner cases: simultaneous requests, a request while busy, reset
// in the middle of a write, and back-to-back traffic at latency 1.
// -----------------------------------------------------------------------------
module tb_main_memory;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  typedef struct {
    bit           rd;
    bit           wr;
    logic [9:0]   addr;
    logic [31:0]  data;
    logic [127:0] blk;
  } vec_t;

  logic         clk;
  logic         reset;

  logic         rd0, wr0, ready0, busy0;
  logic [9:0]   addr0;
  logic [31:0]  wdata0;
  logic [127:0] blk0;

  logic         rd1, wr1, ready1, busy1;
  logic [9:0]   addr1;
  logic [31:0]  wdata1;
  logic [127:0] blk1;

  int checks = 0;
  int errors = 0;

  main_memory #(.WIDTH(32), .ADDR_WIDTH(10), .Block_Size_Byte(16), .LATENCY(LAT0)) dut0 (
    .clk(clk), .reset(reset), .mem_read(rd0), .mem_write(wr0), .address(addr0),
    .write_data(wdata0), .read_ablock(blk0), .ready(ready0), .busy(busy0)
  );

  main_memory #(.WIDTH(32), .ADDR_WIDTH(10), .Block_Size_Byte(16), .LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1), .address(addr1),
    .write_data(wdata1), .read_ablock(blk1), .ready(ready1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Issue one request to dut0 from a negedge. The task follows it to the ready
  // cycle and checks latency, busy, ready and the block. It returns on the
  // negedge after the ready cycle, having checked that ready has dropped.
  task automatic issue0(input bit rd, input bit wr, input logic [9:0] a,
                        input logic [31:0] d, input logic [127:0] exp_blk,
                        input string tag);
    int j;
    rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
    @(negedge clk);
    rd0 = 1'b0; wr0 = 1'b0;
    j = 1;
    while (ready0 !== 1'b1 && j < 40) begin
      chk({tag, " busy_wait"}, 128'(busy0), 128'(1));
      @(negedge clk);
      j++;
    end
    chk({tag, " latency"}, 128'(j), 128'(LAT0 + 1));
    chk({tag, " ready"}, 128'(ready0), 128'(1));
    chk({tag, " busy_at_ready"}, 128'(busy0), 128'(0));
    chk({tag, " block"}, blk0, exp_blk);
    @(negedge clk);
    chk({tag, " ready_drop"}, 128'(ready0), 128'(0));
  endtask

  vec_t vecs[8];
  vec_t ops[6];

  initial begin
    reset = 1'b0;
    rd0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;

    // Write requests leave the block of the previous read in place.
    vecs[0] = '{1'b1, 1'b0, 10'h02D, 32'h0,        {32'h2F, 32'h2E, 32'h2D, 32'h2C}};
    vecs[1] = '{1'b0, 1'b1, 10'h105, 32'hDEADBEEF, {32'h2F, 32'h2E, 32'h2D, 32'h2C}};
    vecs[2] = '{1'b1, 1'b0, 10'h104, 32'h0,        {32'h107, 32'h106, 32'hDEADBEEF, 32'h104}};
    vecs[3] = '{1'b1, 1'b0, 10'h3FF, 32'h0,        {32'h3FF, 32'h3FE, 32'h3FD, 32'h3FC}};
    vecs[4] = '{1'b0, 1'b1, 10'h3FD, 32'hA5A5A5A5, {32'h3FF, 32'h3FE, 32'h3FD, 32'h3FC}};
    vecs[5] = '{1'b1, 1'b0, 10'h3FE, 32'h0,        {32'h3FF, 32'h3FE, 32'hA5A5A5A5, 32'h3FC}};
    vecs[6] = '{1'b0, 1'b1, 10'h000, 32'h11111111, {32'h3FF, 32'h3FE, 32'hA5A5A5A5, 32'h3FC}};
    vecs[7] = '{1'b1, 1'b0, 10'h002, 32'h0,        {32'h3, 32'h2, 32'h1, 32'h11111111}};

    ops[0] = '{1'b0, 1'b1, 10'h0A0, 32'hCAFE0001, 128'h0};
    ops[1] = '{1'b1, 1'b0, 10'h0A0, 32'h0,        {32'hA3, 32'hA2, 32'hA1, 32'hCAFE0001}};
    ops[2] = '{1'b0, 1'b1, 10'h0A3, 32'hCAFE0002, {32'hA3, 32'hA2, 32'hA1, 32'hCAFE0001}};
    ops[3] = '{1'b1, 1'b0, 10'h0A1, 32'h0,        {32'hCAFE0002, 32'hA2, 32'hA1, 32'hCAFE0001}};
    ops[4] = '{1'b0, 1'b1, 10'h0A2, 32'hCAFE0003, {32'hCAFE0002, 32'hA2, 32'hA1, 32'hCAFE0001}};
    ops[5] = '{1'b1, 1'b0, 10'h0A2, 32'h0,        {32'hCAFE0002, 32'hCAFE0003, 32'hA1, 32'hCAFE0001}};

    // Reset state, taken before any clock edge.
    #1;
    chk("reset busy", 128'(busy0), 128'(0));
    chk("reset ready", 128'(ready0), 128'(0));
    chk("reset block", blk0, 128'h0);
    chk("reset block dut1", blk1, 128'h0);

    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Table-driven sequence. The first read is pending at reset release.
    for (int i = 0; i < 8; i++) begin
      issue0(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].blk,
             $sformatf("vec%0d", i));
    end

    // Simultaneous read and write: only the write runs and the block is kept.
    issue0(1'b1, 1'b1, 10'h010, 32'h12345678, {32'h3, 32'h2, 32'h1, 32'h11111111}, "both");
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      chk($sformatf("both no_second_ready s%0d", s), 128'(ready0), 128'(0));
    end
    issue0(1'b1, 1'b0, 10'h013, 32'h0, {32'h13, 32'h12, 32'h11, 32'h12345678}, "both readback");

    // A request while busy is ignored: a single pulse, carrying the first block.
    rd0 = 1'b1; addr0 = 10'h044;
    @(negedge clk);                       // sample 1 after the accept edge
    rd0 = 1'b0;
    for (int s = 2; s <= 10; s++) begin
      @(negedge clk);
      if (s == 2) begin rd0 = 1'b1; addr0 = 10'h3FC; end
      if (s == 3) rd0 = 1'b0;
      chk($sformatf("busyreq ready s%0d", s), 128'(ready0), 128'(s == LAT0 + 1));
      if (s == LAT0 + 1)
        chk("busyreq block", blk0, {32'h47, 32'h46, 32'h45, 32'h44});
    end

    // Reset two cycles into a write: the write is aborted and memory re-initialised.
    wr0 = 1'b1; addr0 = 10'h020; wdata0 = 32'hFFFFFFFF;
    @(negedge clk);
    wr0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset busy", 128'(busy0), 128'(0));
    chk("midreset ready", 128'(ready0), 128'(0));
    chk("midreset block", blk0, 128'h0);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk($sformatf("midreset held ready s%0d", s), 128'(ready0), 128'(0));
    end
    reset = 1'b1;
    issue0(1'b1, 1'b0, 10'h020, 32'h0, {32'h23, 32'h22, 32'h21, 32'h20}, "after_reset 020");
    issue0(1'b1, 1'b0, 10'h104, 32'h0, {32'h107, 32'h106, 32'h105, 32'h104}, "after_reset 104");

    // Latency 1 with requests held continuously: one pulse every two cycles.
    rd1 = ops[0].rd; wr1 = ops[0].wr; addr1 = ops[0].addr; wdata1 = ops[0].data;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("lat1 op%0d busy", i), 128'(busy1), 128'(1));
      chk($sformatf("lat1 op%0d ready_early", i), 128'(ready1), 128'(0));
      if (i + 1 < 6) begin
        rd1 = ops[i+1].rd; wr1 = ops[i+1].wr; addr1 = ops[i+1].addr; wdata1 = ops[i+1].data;
      end else begin
        rd1 = 1'b0; wr1 = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("lat1 op%0d ready", i), 128'(ready1), 128'(1));
      chk($sformatf("lat1 op%0d busy_at_ready", i), 128'(busy1), 128'(0));
      chk($sformatf("lat1 op%0d block", i), blk1, ops[i].blk);
    end
    @(negedge clk);
    chk("lat1 ready_drop", 128'(ready1), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
